// File: rtl/dotprod_ctrl.sv
// dotprod_ctrl: sequencer and SRAM-port owner for one dotprod kernel.
//
// Multiplexes the A/B vector SRAMs between the host loader and the kernel,
// launches the kernel with a latched (clamped) length, supervises the run
// with a watchdog and returns the result over a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   h_wr_en/h_rd_en/h_addr   host SRAM strobes and address (both SRAMs)
//   h_wdata_a/_b, h_rdata_*  host write data / read data pass-through
//   h_busy                   kernel currently owns the SRAMs
//   h_go_valid/ready, h_n    job launch handshake and vector length
//   h_res_valid/ready        result handshake
//   h_result, h_error        dot product (0 on abort), watchdog abort flag
//   k_start, k_n             kernel start pulse and held length
//   k_done, k_result         kernel completion and result
//   k_{a,b}_*                kernel SRAM requests / read data
//   sa_*, sb_*               SRAM A / B ports
module dotprod_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  // host SRAM loader
  input  logic              h_wr_en,
  input  logic              h_rd_en,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata_a,
  input  logic [DATA_W-1:0] h_wdata_b,
  output logic [DATA_W-1:0] h_rdata_a,
  output logic [DATA_W-1:0] h_rdata_b,
  output logic              h_busy,
  // host job control
  input  logic              h_go_valid,
  output logic              h_go_ready,
  input  logic [DATA_W-1:0] h_n,
  output logic              h_res_valid,
  input  logic              h_res_ready,
  output logic [DATA_W-1:0] h_result,
  output logic              h_error,
  // kernel control
  output logic              k_start,
  output logic [DATA_W-1:0] k_n,
  input  logic              k_done,
  input  logic [DATA_W-1:0] k_result,
  // kernel SRAM requests
  input  logic [ADDR_W-1:0] k_a_addr,
  input  logic [ADDR_W-1:0] k_b_addr,
  input  logic              k_a_rd_en,
  input  logic              k_a_wr_en,
  input  logic              k_b_rd_en,
  input  logic              k_b_wr_en,
  input  logic [DATA_W-1:0] k_a_wdata,
  input  logic [DATA_W-1:0] k_b_wdata,
  output logic [DATA_W-1:0] k_a_rdata,
  output logic [DATA_W-1:0] k_b_rdata,
  // SRAM A port
  output logic [ADDR_W-1:0] sa_addr,
  output logic              sa_rd_en,
  output logic              sa_wr_en,
  output logic [DATA_W-1:0] sa_wdata,
  input  logic [DATA_W-1:0] sa_rdata,
  // SRAM B port
  output logic [ADDR_W-1:0] sb_addr,
  output logic              sb_rd_en,
  output logic              sb_wr_en,
  output logic [DATA_W-1:0] sb_wdata,
  input  logic [DATA_W-1:0] sb_rdata
);

  // Watchdog must hold the value TIMEOUT itself.
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Length clamp compared in a width that can represent 2^ADDR_W.
  localparam int unsigned NC_W = (ADDR_W >= DATA_W) ? ADDR_W + 1 : DATA_W + 1;
  localparam logic [NC_W-1:0] N_MAX = NC_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_RUN,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [WD_W-1:0]   wdog_q;
  logic              busy_q;
  logic              go_ready_q;
  logic              start_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] kn_q;
  logic [DATA_W-1:0] result_q;
  logic              error_q;

  logic [DATA_W-1:0] n_eff_c;
  logic              timeout_c;

  // n_eff = min(h_n, 2^ADDR_W)
  always_comb begin
    n_eff_c = h_n;
    if (NC_W'(h_n) > N_MAX) begin
      n_eff_c = DATA_W'(N_MAX);
    end
  end

  // RUN cycle index equals wdog_q; abort decision is taken in RUN cycle TIMEOUT.
  assign timeout_c = (wdog_q == WD_W'(TIMEOUT));

  // Sequencer: state, watchdog and all registered host/kernel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wdog_q      <= '0;
      busy_q      <= 1'b0;
      go_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      kn_q        <= '0;
      result_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (h_go_valid) begin
            kn_q       <= n_eff_c;
            error_q    <= 1'b0;
            go_ready_q <= 1'b0;
            if (n_eff_c == '0) begin
              // Empty job: answer immediately, kernel never started.
              result_q    <= '0;
              res_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_START;
            end
          end
        end
        S_START: begin
          wdog_q  <= '0;
          state_q <= S_ARM;
        end
        S_ARM: begin
          // k_done may still be the previous job's flag here.
          state_q <= S_RUN;
        end
        S_RUN: begin
          wdog_q <= wdog_q + WD_W'(1);
          if (k_done || timeout_c) begin
            result_q    <= k_done ? k_result : '0;
            error_q     <= ~k_done;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (h_res_ready) begin
            res_valid_q <= 1'b0;
            go_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          go_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM ownership mux; busy_q mirrors START/ARM/RUN exactly.
  always_comb begin
    if (busy_q) begin
      sa_addr  = k_a_addr;
      sa_rd_en = k_a_rd_en;
      sa_wr_en = k_a_wr_en;
      sa_wdata = k_a_wdata;
      sb_addr  = k_b_addr;
      sb_rd_en = k_b_rd_en;
      sb_wr_en = k_b_wr_en;
      sb_wdata = k_b_wdata;
    end else begin
      // Host write wins over a simultaneous host read.
      sa_addr  = h_addr;
      sa_rd_en = h_rd_en & ~h_wr_en;
      sa_wr_en = h_wr_en;
      sa_wdata = h_wdata_a;
      sb_addr  = h_addr;
      sb_rd_en = h_rd_en & ~h_wr_en;
      sb_wr_en = h_wr_en;
      sb_wdata = h_wdata_b;
    end
  end

  assign h_rdata_a   = sa_rdata;
  assign h_rdata_b   = sb_rdata;
  assign k_a_rdata   = sa_rdata;
  assign k_b_rdata   = sb_rdata;

  assign h_busy      = busy_q;
  assign h_go_ready  = go_ready_q;
  assign h_res_valid = res_valid_q;
  assign h_result    = result_q;
  assign h_error     = error_q;
  assign k_start     = start_q;
  assign k_n         = kn_q;

endmodule

// File: tb/tb_dotprod_ctrl.sv
// Testbench for dotprod_ctrl: SRAM models, behavioural kernel, result scoreboard.
module tb_dotprod_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          rst;
  logic          h_wr_en, h_rd_en;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata_a, h_wdata_b, h_rdata_a, h_rdata_b;
  logic          h_busy, h_go_valid, h_go_ready;
  logic [DW-1:0] h_n;
  logic          h_res_valid, h_res_ready;
  logic [DW-1:0] h_result;
  logic          h_error;
  logic          k_start;
  logic [DW-1:0] k_n;
  logic          k_done;
  logic [DW-1:0] k_result;
  logic [AW-1:0] k_a_addr, k_b_addr;
  logic          k_a_rd_en, k_a_wr_en, k_b_rd_en, k_b_wr_en;
  logic [DW-1:0] k_a_wdata, k_b_wdata, k_a_rdata, k_b_rdata;
  logic [AW-1:0] sa_addr, sb_addr;
  logic          sa_rd_en, sa_wr_en, sb_rd_en, sb_wr_en;
  logic [DW-1:0] sa_wdata, sb_wdata, sa_rdata, sb_rdata;

  dotprod_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .h_wr_en(h_wr_en), .h_rd_en(h_rd_en), .h_addr(h_addr),
    .h_wdata_a(h_wdata_a), .h_wdata_b(h_wdata_b),
    .h_rdata_a(h_rdata_a), .h_rdata_b(h_rdata_b), .h_busy(h_busy),
    .h_go_valid(h_go_valid), .h_go_ready(h_go_ready), .h_n(h_n),
    .h_res_valid(h_res_valid), .h_res_ready(h_res_ready),
    .h_result(h_result), .h_error(h_error),
    .k_start(k_start), .k_n(k_n), .k_done(k_done), .k_result(k_result),
    .k_a_addr(k_a_addr), .k_b_addr(k_b_addr),
    .k_a_rd_en(k_a_rd_en), .k_a_wr_en(k_a_wr_en),
    .k_b_rd_en(k_b_rd_en), .k_b_wr_en(k_b_wr_en),
    .k_a_wdata(k_a_wdata), .k_b_wdata(k_b_wdata),
    .k_a_rdata(k_a_rdata), .k_b_rdata(k_b_rdata),
    .sa_addr(sa_addr), .sa_rd_en(sa_rd_en), .sa_wr_en(sa_wr_en),
    .sa_wdata(sa_wdata), .sa_rdata(sa_rdata),
    .sb_addr(sb_addr), .sb_rd_en(sb_rd_en), .sb_wr_en(sb_wr_en),
    .sb_wdata(sb_wdata), .sb_rdata(sb_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Synchronous-read SRAM models, one cycle read latency.
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    sa_rdata = '0;
    sb_rdata = '0;
  end
  always @(posedge clk) begin
    if (sa_wr_en) mem_a[sa_addr] <= sa_wdata;
    if (sa_rd_en) sa_rdata <= mem_a[sa_addr];
    if (sb_wr_en) mem_b[sb_addr] <= sb_wdata;
    if (sb_rd_en) sb_rdata <= mem_b[sb_addr];
  end

  // Kernel model. kmode 0: real dot product, 1: never done,
  // 2: done forced in RUN cycle 16 with result 0x1234.
  int            kmode;
  logic          krun, kpend, kdone;
  logic [4:0]    kidx;
  logic [DW-1:0] kn, kacc, kres;
  int            kcyc;

  assign k_a_addr  = kidx[AW-1:0];
  assign k_b_addr  = kidx[AW-1:0];
  assign k_a_rd_en = krun && (32'(kidx) < kn);
  assign k_b_rd_en = k_a_rd_en;
  assign k_a_wr_en = 1'b0;
  assign k_b_wr_en = 1'b0;
  assign k_a_wdata = '0;
  assign k_b_wdata = '0;
  assign k_done    = (kmode == 2) ? (kcyc == 18) : kdone;
  assign k_result  = (kmode == 2) ? 32'h0000_1234 : kres;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      krun <= 0; kpend <= 0; kdone <= 0; kidx <= 0;
      kn <= 0; kacc <= 0; kres <= 0; kcyc <= 0;
    end else begin
      kcyc <= kcyc + 1;
      if (k_start) begin
        krun <= 1; kidx <= 0; kacc <= 0; kpend <= 0; kn <= k_n; kcyc <= 1;
      end else if (krun) begin
        kdone <= 0;  // stale flag stays high through the ARM cycle
        if (kpend) kacc <= kacc + k_a_rdata * k_b_rdata;
        kpend <= k_a_rd_en;
        if (k_a_rd_en) kidx <= kidx + 5'd1;
        if (!k_a_rd_en && !kpend) begin
          krun <= 0;
          if (kmode == 0) begin
            kdone <= 1;
            kres  <= kacc;
          end
        end
      end
    end
  end

  int start_cnt = 0;
  always @(posedge clk) if (k_start) start_cnt++;

  // Scoreboard: expectations pushed at go, popped at result handshake.
  typedef struct {
    logic [DW-1:0] res;
    logic          err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst && h_res_valid && h_res_ready) begin
      check("sb_pending", 64'(sb_q.size()), 64'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("sb_result", h_result, mon_e.res);
        check("sb_error", h_error, mon_e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int addr, input logic [DW-1:0] a, input logic [DW-1:0] b);
    h_addr = AW'(addr); h_wdata_a = a; h_wdata_b = b; h_wr_en = 1'b1;
    tick();
    h_wr_en = 1'b0;
  endtask

  task automatic host_read(input string tag, input int addr, input logic [DW-1:0] ea,
                           input logic [DW-1:0] eb);
    h_addr = AW'(addr); h_rd_en = 1'b1;
    tick();
    h_rd_en = 1'b0;
    check({tag, "_a"}, h_rdata_a, ea);
    check({tag, "_b"}, h_rdata_b, eb);
  endtask

  // Returns at #1 after the accepting edge.
  task automatic do_go(input logic [DW-1:0] n, input logic [DW-1:0] er, input logic ee);
    exp_t e;
    int w;
    w = 0;
    while (!h_go_ready && w < 100) begin tick(); w++; end
    if (!h_go_ready) check("go_ready_wait", h_go_ready, 1);
    e.res = er; e.err = ee;
    sb_q.push_back(e);
    h_n = n; h_go_valid = 1'b1;
    tick();
    h_go_valid = 1'b0;
  endtask

  task automatic wait_res(input int max, output int cyc);
    cyc = 0;
    while (!h_res_valid && cyc < max) begin tick(); cyc++; end
    if (!h_res_valid) check("res_wait", h_res_valid, 1);
  endtask

  int cyc, sc;

  initial begin
    rst = 0; h_wr_en = 0; h_rd_en = 0; h_addr = '0; h_wdata_a = '0; h_wdata_b = '0;
    h_go_valid = 0; h_n = '0; h_res_ready = 1; kmode = 0;
    tick(); tick();
    check("rst_go_ready", h_go_ready, 1);
    check("rst_busy", h_busy, 0);
    check("rst_res_valid", h_res_valid, 0);
    check("rst_k_start", k_start, 0);
    check("rst_k_n", k_n, 0);
    check("rst_result", h_result, 0);
    check("rst_error", h_error, 0);
    rst = 1;
    tick();

    // Write beats read on the host side.
    h_addr = '0; h_wdata_a = 32'd1; h_wdata_b = 32'd5; h_wr_en = 1; h_rd_en = 1;
    #1;
    check("wr_wins_rd", sa_rd_en, 0);
    check("wr_wins_wr", sa_wr_en, 1);
    tick();
    h_wr_en = 0; h_rd_en = 0;
    for (int i = 1; i < 4; i++) host_write(i, DW'(i + 1), DW'(i + 5));
    host_read("rd_pre", 2, 3, 7);

    // Basic job with ownership probe and backpressure.
    h_res_ready = 0;
    sc = start_cnt;
    do_go(4, 70, 0);
    check("j1_k_start", k_start, 1);
    check("j1_busy", h_busy, 1);
    check("j1_k_n", k_n, 4);
    check("j1_go_ready", h_go_ready, 0);
    tick();
    check("j1_arm_k_start", k_start, 0);
    h_addr = 2; h_wdata_a = 99; h_wdata_b = 99; h_wr_en = 1;
    #1;
    check("own_wr_dropped", sa_wr_en, 0);
    check("own_addr_a", sa_addr, k_a_addr);
    check("own_addr_b", sb_addr, k_b_addr);
    check("own_rd_en", sa_rd_en, k_a_rd_en);
    tick();
    h_wr_en = 0;
    wait_res(50, cyc);
    check("j1_busy_low", h_busy, 0);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", h_res_valid, 1);
      check("bp_result", h_result, 70);
      check("bp_error", h_error, 0);
      check("bp_go_ready", h_go_ready, 0);
      tick();
    end
    check("j1_one_start", 64'(start_cnt - sc), 1);
    h_res_ready = 1;
    tick();
    check("j1_res_dropped", h_res_valid, 0);
    host_read("rd_post", 2, 3, 7);

    // Second job reuses the loaded vectors.
    do_go(2, 17, 0);
    wait_res(50, cyc);
    tick();

    // Zero length answers immediately without starting the kernel.
    sc = start_cnt;
    do_go(0, 0, 0);
    check("z_res_valid", h_res_valid, 1);
    check("z_busy", h_busy, 0);
    check("z_k_n", k_n, 0);
    tick();
    check("z_no_start", 64'(start_cnt - sc), 0);

    // Length clamp plus watchdog abort.
    kmode = 1;
    do_go(100, 0, 1);
    check("clamp_k_n", k_n, 16);
    wait_res(60, cyc);
    check("wd_latency", 64'(cyc), 64'(TO + 3));
    tick();
    check("wd_err_hold", h_error, 1);

    rst = 0; #1; rst = 1;
    tick();

    // Done in the same cycle as the timeout wins.
    kmode = 2;
    do_go(3, 32'h1234, 0);
    wait_res(60, cyc);
    check("dw_latency", 64'(cyc), 64'(TO + 3));
    tick();

    // Reset in the middle of RUN.
    kmode = 1;
    do_go(3, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check("mr_busy", h_busy, 1);
    h_addr = 5; h_rd_en = 1;
    rst = 0;
    #1;
    check("mr_busy_rst", h_busy, 0);
    check("mr_go_ready", h_go_ready, 1);
    check("mr_k_start", k_start, 0);
    check("mr_k_n", k_n, 0);
    check("mr_result", h_result, 0);
    check("mr_res_valid", h_res_valid, 0);
    check("mr_error", h_error, 0);
    check("mr_sa_addr", sa_addr, 5);
    check("mr_sa_rd_en", sa_rd_en, 1);
    h_rd_en = 0;
    sb_q.delete();
    tick();
    rst = 1;
    tick();

    kmode = 0;
    do_go(4, 70, 0);
    check("ar_k_start", k_start, 1);
    wait_res(50, cyc);
    tick();
    check("sb_drained", 64'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
